// File: rtl/find_max_driver_pkg.sv
// -----------------------------------------------------------------------------
// find_max_pkg
// Shared definitions for the find_max driver (transmit-side partner of the
// find_max receiver).
//   DW      : sample width, matches the receiver data width
//   state_t : driver FSM states (IDLE / SEND / WAIT)
//   data_t  : one sample / one result word
// -----------------------------------------------------------------------------
package find_max_pkg;

   localparam int DW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/find_max_driver_if.sv
// -----------------------------------------------------------------------------
// find_max_driver_if
// Bundles the driver's loading port, control/status, the transmit stream
// towards the receiver and the receiver's result return path.
//   wr_en/wr_data/wr_full       : sample loading
//   start/busy/done/timeout     : burst control and status
//   tx_data/tx_ena              : enable-framed stream to receiver
//   rx_max/rx_submax/rx_ena     : receiver result and its one-cycle pulse
//   res_max/res_submax          : captured result
//   mismatch                    : only with FIND_MAX_DRIVER_SELFCHECK_EN
// Modports: master = driver side, slave = environment (host + receiver).
// -----------------------------------------------------------------------------
interface find_max_driver_if;
   import find_max_pkg::*;

   logic  wr_en;
   data_t wr_data;
   logic  wr_full;
   logic  start;
   logic  busy;
   data_t tx_data;
   logic  tx_ena;
   data_t rx_max;
   data_t rx_submax;
   logic  rx_ena;
   data_t res_max;
   data_t res_submax;
   logic  done;
   logic  timeout;
`ifdef FIND_MAX_DRIVER_SELFCHECK_EN
   logic  mismatch;

   modport master (
      input  wr_en, wr_data, start, rx_max, rx_submax, rx_ena,
      output wr_full, busy, tx_data, tx_ena, res_max, res_submax, done,
             timeout, mismatch
   );

   modport slave (
      output wr_en, wr_data, start, rx_max, rx_submax, rx_ena,
      input  wr_full, busy, tx_data, tx_ena, res_max, res_submax, done,
             timeout, mismatch
   );
`else
   modport master (
      input  wr_en, wr_data, start, rx_max, rx_submax, rx_ena,
      output wr_full, busy, tx_data, tx_ena, res_max, res_submax, done,
             timeout
   );

   modport slave (
      output wr_en, wr_data, start, rx_max, rx_submax, rx_ena,
      input  wr_full, busy, tx_data, tx_ena, res_max, res_submax, done,
             timeout
   );
`endif

endinterface

// File: rtl/find_max_driver_burst_buf.sv
// -----------------------------------------------------------------------------
// find_max_burst_buf
// Small sample buffer for one burst. Samples are appended at index count;
// the whole buffer is emptied with clr once a burst completes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count only)
//   wr_en     : write request (already qualified by the FSM state)
//   wr_data   : sample to append
//   clr       : empty the buffer (count -> 0)
//   rd_addr   : read address, sampled every clock
//   rd_data   : registered read data
//   wr_ack    : the write request is accepted this cycle
//   count     : number of stored samples (0..DEPTH)
//   full      : count == DEPTH
// -----------------------------------------------------------------------------
module find_max_burst_buf
   import find_max_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  data_t                    wr_data,
   input  logic                     clr,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output data_t                    rd_data,
   output logic                     wr_ack,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   data_t          mem [DEPTH];
   data_t          rd_data_reg;
   logic [CW-1:0]  count_reg;
   logic [AW-1:0]  wr_addr;

   assign wr_addr = count_reg[AW-1:0];
   assign full    = (count_reg == CW'(DEPTH));
   assign wr_ack  = wr_en && !full;
   assign count   = count_reg;
   assign rd_data = rd_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (wr_ack) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // Storage is not reset. Write-first forwarding covers a start that
   // coincides with the very write landing on the first read address.
   always_ff @(posedge clk) begin
      if (wr_ack) begin
         mem[wr_addr] <= wr_data;
      end
      if (wr_ack && (wr_addr == rd_addr)) begin
         rd_data_reg <= wr_data;
      end else begin
         rd_data_reg <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/find_max_driver.sv
// -----------------------------------------------------------------------------
// find_max_driver
// Loads a burst of samples, streams them to the find_max receiver as one
// contiguous tx_ena-framed run, then waits for the receiver's result pulse
// and captures max/submax (done), or gives up after TIMEOUT WAIT cycles
// (done + sticky timeout).
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : find_max_driver_if.master (load, control, stream, result)
// Parameters:
//   DEPTH   : buffer entries / maximum burst length (power of two, >= 2)
//   TIMEOUT : WAIT cycles allowed before a timeout (>= 3)
// Optional build macro FIND_MAX_DRIVER_SELFCHECK_EN adds a shadow of the
// receiver's max/submax rule and a sticky bus.mismatch flag raised when a
// captured result differs from the shadow.
// -----------------------------------------------------------------------------
module find_max_driver
   import find_max_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               rst,
   find_max_driver_if.master  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);

   state_t         state_reg, state_next;
   logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [TW-1:0]  wait_reg, wait_next;
   logic           tx_ena_reg, tx_ena_next;
   logic           done_reg, done_next;
   logic           timeout_reg, timeout_next;
   data_t          res_max_reg, res_max_next;
   data_t          res_submax_reg, res_submax_next;

   logic           wr_req;
   logic           wr_ack;
   logic           clr;
   logic           full;
   logic [CW-1:0]  count;
   data_t          rd_data;
   data_t          tx_data;
   logic           start_ok;
   logic           last;
   logic           capture;

   // Loading is only possible while idle.
   assign wr_req = bus.wr_en && (state_reg == IDLE);

   find_max_burst_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_req),
      .wr_data (bus.wr_data),
      .clr     (clr),
      .rd_addr (rd_ptr_next),
      .rd_data (rd_data),
      .wr_ack  (wr_ack),
      .count   (count),
      .full    (full)
   );

   // A write accepted in the same cycle as start already counts toward the
   // burst, so an empty buffer plus coincident write still starts.
   assign start_ok = (state_reg == IDLE) && bus.start && ((count != '0) || wr_ack);
   assign last     = ({1'b0, rd_ptr_reg} == (count - CW'(1)));
   assign capture  = (state_reg == WAIT) && bus.rx_ena;

   always_comb begin
      state_next      = state_reg;
      rd_ptr_next     = rd_ptr_reg;
      wait_next       = wait_reg;
      tx_ena_next     = tx_ena_reg;
      done_next       = 1'b0;
      timeout_next    = timeout_reg;
      res_max_next    = res_max_reg;
      res_submax_next = res_submax_reg;
      clr             = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               state_next   = SEND;
               rd_ptr_next  = '0;
               tx_ena_next  = 1'b1;
               timeout_next = 1'b0;
            end
         end
         SEND: begin
            // rd_ptr_reg is the sample on the wire this cycle; the buffer
            // fetches rd_ptr_next for the following cycle.
            if (last) begin
               state_next  = WAIT;
               tx_ena_next = 1'b0;
               wait_next   = '0;
            end else begin
               rd_ptr_next = rd_ptr_reg + AW'(1);
            end
         end
         WAIT: begin
            if (capture) begin
               res_max_next    = bus.rx_max;
               res_submax_next = bus.rx_submax;
               done_next       = 1'b1;
               clr             = 1'b1;
               state_next      = IDLE;
            end else if (wait_reg == TW'(TIMEOUT - 1)) begin
               done_next    = 1'b1;
               timeout_next = 1'b1;
               clr          = 1'b1;
               state_next   = IDLE;
            end else begin
               wait_next = wait_reg + TW'(1);
            end
         end
         default: begin
            state_next  = IDLE;
            tx_ena_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         rd_ptr_reg     <= '0;
         wait_reg       <= '0;
         tx_ena_reg     <= 1'b0;
         done_reg       <= 1'b0;
         timeout_reg    <= 1'b0;
         res_max_reg    <= '0;
         res_submax_reg <= '0;
      end else begin
         state_reg      <= state_next;
         rd_ptr_reg     <= rd_ptr_next;
         wait_reg       <= wait_next;
         tx_ena_reg     <= tx_ena_next;
         done_reg       <= done_next;
         timeout_reg    <= timeout_next;
         res_max_reg    <= res_max_next;
         res_submax_reg <= res_submax_next;
      end
   end

   // Gating with tx_ena keeps the stream at zero outside the frame and makes
   // it fall to zero together with tx_ena on an asynchronous reset.
   assign tx_data        = tx_ena_reg ? rd_data : '0;

   assign bus.tx_data    = tx_data;
   assign bus.tx_ena     = tx_ena_reg;
   assign bus.wr_full    = full;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.done       = done_reg;
   assign bus.timeout    = timeout_reg;
   assign bus.res_max    = res_max_reg;
   assign bus.res_submax = res_submax_reg;

`ifdef FIND_MAX_DRIVER_SELFCHECK_EN
   data_t ref_max_reg, ref_max_next;
   data_t ref_submax_reg, ref_submax_next;
   logic  mismatch_reg, mismatch_next;

   // Same update rule as the receiver: only a strictly larger sample moves
   // the old max down into submax; anything else leaves both untouched.
   always_comb begin
      ref_max_next    = ref_max_reg;
      ref_submax_next = ref_submax_reg;
      mismatch_next   = mismatch_reg;
      if (tx_ena_reg && (tx_data > ref_max_reg)) begin
         ref_submax_next = ref_max_reg;
         ref_max_next    = tx_data;
      end
      if (capture && ((bus.rx_max != ref_max_reg) || (bus.rx_submax != ref_submax_reg))) begin
         mismatch_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_max_reg    <= '0;
         ref_submax_reg <= '0;
         mismatch_reg   <= 1'b0;
      end else begin
         ref_max_reg    <= ref_max_next;
         ref_submax_reg <= ref_submax_next;
         mismatch_reg   <= mismatch_next;
      end
   end

   assign bus.mismatch = mismatch_reg;
`endif

endmodule

// File: doc/find_max_driver.md
Name: find_max_driver

Overview:
Transmit-side partner for the find_max receiver in the max-search path.
- Software or a test sequencer loads a burst of samples into a small local buffer.
- On `start`, the block emits them as one contiguous enable-framed stream (`tx_data`/`tx_ena`).
- It then waits for the receiver's one-cycle result pulse, captures max/submax and reports `done`, or reports `timeout` if no pulse arrives.

Parameters:
- DW, 5, sample width; matches the receiver data width.
- DEPTH, 16, buffer entries (maximum burst length); power of two, ≥2.
- TIMEOUT, 8, number of WAIT cycles allowed for `rx_ena` before timeout; ≥3.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  load strobe; one sample written per cycle.
- wr_data  in  DW  sample to load.
- wr_full  out  1  buffer holds DEPTH samples.
- start  in  1  begin transmission of the loaded burst.
- busy  out  1  high in SEND and WAIT.
- tx_data  out  DW  stream sample to the receiver `datain`.
- tx_ena  out  1  stream framing to the receiver `datain_ena`.
- rx_max  in  DW  receiver `max`.
- rx_submax  in  DW  receiver `submax`.
- rx_ena  in  1  receiver `dataout_ena` result pulse.
- res_max  out  DW  captured max.
- res_submax  out  DW  captured submax.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky: last burst ended without `rx_ena`.

Behaviour:
- Reset values: all outputs and state are zero.
  - FSM = IDLE, count = 0, rd_ptr = 0.
  - `tx_ena` drops asynchronously when `rst` rises, including mid-burst.
  - Buffer contents need not be reset.
- FSM states: IDLE, SEND, WAIT.
- IDLE, loading:
  - `wr_en` with count < DEPTH writes `buf[count]` and increments count.
  - `wr_en` when `wr_full` is high, or when not in IDLE, is silently dropped.
  - `wr_full` = (count == DEPTH).
- IDLE, start:
  - `start` with count > 0 moves to SEND, clears `timeout` and sets rd_ptr = 0.
  - `start` with count = 0, or `start` outside IDLE, is ignored.
  - If `wr_en` and `start` coincide in IDLE, the write is accepted first. The burst includes the new sample.
- SEND:
  - If `start` is sampled at edge 0, `tx_ena` is registered high for exactly N = count cycles, cycles 1..N, with no gaps.
  - `tx_data` = `buf[i]` in cycle i+1.
  - `tx_data` is 0 whenever `tx_ena` is low.
  - After the last sample, the FSM enters WAIT in cycle N+1 with `tx_ena` low. This creates the falling edge the receiver detects.
- WAIT:
  - A wait counter runs from entry.
  - The receiver raises `rx_ena` in cycle N+2.
  - `rx_ena` sampled in WAIT latches `rx_max`/`rx_submax` into `res_*`. `done` is high the next cycle, count clears, and the FSM returns to IDLE.
  - If TIMEOUT WAIT cycles elapse with no `rx_ena`, `done` and `timeout` are set together in cycle N+1+TIMEOUT. `res_*` holds its previous values, count clears and the FSM returns to IDLE.
  - `rx_ena` outside WAIT is ignored.
- `res_*` holds until the next capture or reset.
- The receiver keeps running max/submax across bursts (not cleared per burst). The driver does not compensate; results are cumulative since receiver reset.

Optional Feature:
Macro FIND_MAX_DRIVER_SELFCHECK_EN.
- When defined:
  - Adds output `mismatch` (1 bit, sticky, cleared by `rst` only).
  - Adds an internal reference model updated on every transmitted sample, using the receiver's rule: if sample > ref_max, then ref_submax ← ref_max and ref_max ← sample; otherwise unchanged. Equal samples do not update.
  - On capture, `mismatch` is set if `res_*` ≠ `ref_*`.
  - A timeout does not set `mismatch`.
  - The model resets with `rst`, so it stays aligned only when both blocks share reset.
- When undefined: no port, no model logic.

Decomposition:
- Package `find_max_pkg`:
  - `DW` localparam.
  - FSM state enum typedef (IDLE/SEND/WAIT).
  - Data typedef `logic [DW-1:0]`.
- Sub-module `find_max_burst_buf`:
  - Holds the write pointer/count, synchronous write, registered read by rd_ptr, and `full` flag.
  - The top keeps the FSM, wait counter, capture and self-check.

Test Plan:
1. Reset, load {3,7,5}, `start` at cycle 0 → `tx_ena` high cycles 1-3 with data 3,7,5; `rx_ena` in cycle 5; `done` in cycle 6; `res_max`=7, `res_submax`=3; `timeout`=0.
2. Following test 1 without reset, load {2,9,9} → `res_max`=9, `res_submax`=7 (equal 9 does not shift submax); `mismatch`=0 with macro defined.
3. Tie `rx_ena`=0, load {4}, start → `tx_ena` in cycle 1 only; `done` and `timeout` high in cycle 10 (TIMEOUT=8); `res_*` unchanged; next `start` clears `timeout`.
4. Write 17 samples 0..16 → `wr_full` high after 16th; 17th dropped; burst is 16 samples, 0..15; `res_max`=15, `res_submax`=14.
5. `start` with empty buffer, and `start`/`wr_en` pulsed during SEND → ignored; stream length and contents unchanged.
6. Assert `rst` during cycle 2 of a 4-sample burst → `tx_ena` low immediately; all outputs 0; FSM IDLE; count 0; later load/start behaves as test 1.
